prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the program memory. Receives a byte stream from the UART receiver and assembles big-endian 32-bit instruction words.
- Writes the words sequentially into program memory through its write port, starting at word address 0.
- Asserts done when loading is complete, which releases the core to start fetching at pc=0.
- Stream format: 4-byte big-endian word count N, then N words, each big-endian (MSB byte first).

Parameters:
- MEM, 10, byte-address width of program memory; word address width is MEM-2; capacity is 1<<(MEM-2) words.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte; a transfer happens when rx_valid & rx_ready.
- prog_we  out  1  one-cycle program-memory write strobe.
- prog_addr  out  MEM-2  word address for the write.
- prog_din  out  32  instruction word to write.
- done  out  1  load complete; stays high until reset.
- err  out  1  header count exceeds capacity; stays high until reset.

Behaviour:
- Reset (async, rstn=0): state=S_LEN, byte counter=0, word counter=0, shift register=0.
  - Outputs: prog_we=0, prog_addr=0, prog_din=0, done=0, err=0, rx_ready=0.
  - Reset mid-load aborts the load; memory contents already written are left as is.
  - After rstn deasserts, rx_ready goes high on the first clock edge.
- rx_ready is registered: 1 in S_LEN and S_DATA, 0 in S_DONE and S_ERR. The write path never stalls input.
- S_LEN: each accepted byte shifts into shift_reg as shift_reg <= {shift_reg[23:0], rx_data}; the byte counter increments mod 4. On the 4th byte, N = the assembled value (32-bit, unsigned):
  - N == 0: next state is S_DONE; done=1 the next cycle; no write occurs.
  - N > 1<<(MEM-2): next state is S_ERR; err=1 the next cycle.
  - Otherwise: next state is S_DATA; the remaining-word count is loaded with N.
- S_DATA: bytes are assembled the same way. In the cycle after the 4th byte is accepted:
  - prog_we=1, prog_din=the assembled word, prog_addr=the word counter value.
  - The word counter then increments and the remaining count decrements.
  - Latency: exactly 1 cycle from the accepting edge of the last byte to the prog_we pulse.
- Last word (remaining==1 when its 4th byte is accepted): the write pulse and done=1 occur in the same cycle; state moves to S_DONE.
- prog_we is high for one cycle per word only. prog_addr and prog_din hold their last values afterwards.
- Back-to-back bytes (rx_valid held high every cycle) are accepted at 1 byte/cycle with no bubbles.
- A gap in rx_valid between bytes changes neither the byte counter nor the shift register.
- N equal to capacity is legal: the final write goes to address (1<<(MEM-2))-1, and the word counter wraps to 0 without effect.
- S_DONE and S_ERR are terminal. Further bytes are ignored (rx_ready=0); exit is by reset only.
- done and err are never both high.

Decomposition:
- Package prog_loader_pkg:
  - State enum {S_LEN, S_DATA, S_DONE, S_ERR}.
  - Constant BYTES_PER_WORD=4.
  - Function capacity(MEM) = 1<<(MEM-2).
- Sub-module word_assembler:
  - Contains the 2-bit byte counter and 32-bit shift register.
  - Inputs: byte plus strobe. Output: a one-cycle word_valid pulse with the assembled word.
  - Shared by the header and data phases; the top level holds the FSM and the address/count logic.

Test Plan:
- Header 00 00 00 02, then bytes 01 02 03 04 AA BB CC DD back-to-back.
  - Required: prog_we at addr 0 with 0x01020304, then at addr 1 with 0xAABBCCDD.
  - done=1 in the same cycle as the second write; rx_ready=0 afterwards.
- Header 00 00 00 00.
  - Required: no prog_we pulses; done=1 one cycle after the 4th header byte.
- MEM=10, header 00 00 01 01 (257 > 256).
  - Required: err=1, done=0, no writes; further bytes are not accepted.
- MEM=10, header 00 00 01 00, then 256 words with random gaps in rx_valid.
  - Required: 256 writes to addrs 0..255, each with the correct word; done after the addr 255 write.
- rstn pulsed low after 2 of 3 words are written, then a new stream with header 00 00 00 01 and word DE AD BE EF.
  - Required: outputs clear asynchronously; the new load writes 0xDEADBEEF to addr 0; done=1.
- Gap check: byte 0x11, rx_valid low for 5 cycles, then 22 33 44 (header N=1 already sent).
  - Required: a single write of 0x11223344 at addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Number of 32-bit words that fit in a program memory with 'mem' byte-address bits.
  function automatic logic [32:0] capacity(input int mem);
    capacity = 33'(1) << (mem - 2);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word assembler shared by the header and data phases.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  output logic        word_valid,
  output logic [31:0] word_out
);

  localparam int                CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BYTES_PER_WORD - 1);

  // Only the three earlier bytes are stored; the fourth is taken straight
  // from byte_in so the word is available in the cycle it is accepted.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;

  // Advance the byte counter and shift in a byte only on an accepted strobe.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_stb) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  assign word_valid = byte_stb && (cnt_q == LAST);
  assign word_out   = {shift_q, byte_in};

  // Counter and shift register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: parses a word-count header from the byte stream,
// then writes that many big-endian words to consecutive word addresses.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            prog_we,
  output logic [MEM-3:0]  prog_addr,
  output logic [31:0]     prog_din,
  output logic            done,
  output logic            err
);

  localparam int          AW  = MEM - 2;
  localparam int          RW  = MEM - 1;  // remaining count must reach capacity itself
  localparam logic [32:0] CAP = capacity(MEM);

  state_e          state_q, state_d;
  logic            rx_ready_q, rx_ready_d;
  logic            prog_we_q, prog_we_d;
  logic [AW-1:0]   prog_addr_q, prog_addr_d;
  logic [31:0]     prog_din_q, prog_din_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [RW-1:0]   rem_q, rem_d;

  logic            byte_stb;
  logic            word_valid;
  logic [31:0]     word;

  // rx_ready is only high in the loading states, so this also gates the terminal states.
  assign byte_stb = rx_valid && rx_ready_q;

  word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .byte_in    (rx_data),
    .byte_stb   (byte_stb),
    .word_valid (word_valid),
    .word_out   (word)
  );

  // Next-state and registered-output logic for the header/data/terminal FSM.
  always_comb begin
    state_d     = state_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_din_d  = prog_din_q;
    done_d      = done_q;
    err_d       = err_q;
    word_cnt_d  = word_cnt_q;
    rem_d       = rem_q;

    unique case (state_q)
      S_LEN: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ({1'b0, word} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d    = S_DATA;
            rem_d      = word[RW-1:0];
            word_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (word_valid) begin
          prog_we_d   = 1'b1;
          prog_din_d  = word;
          prog_addr_d = word_cnt_q;
          // Wraps to 0 after a full-capacity load; harmless since loading ends there.
          word_cnt_d  = word_cnt_q + AW'(1);
          rem_d       = rem_q - RW'(1);
          if (rem_q == RW'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
  end

  // FSM state and all outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_LEN;
      rx_ready_q  <= 1'b0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_din_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_din_q  <= prog_din_d;
      done_q      <= done_d;
      err_q       <= err_d;
      word_cnt_q  <= word_cnt_d;
      rem_q       <= rem_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign prog_we   = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_din  = prog_din_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a stream-level model predicts every
// memory write and the final done/err state; a monitor checks each write.
module tb_prog_loader;

  localparam int MEM = 10;
  localparam int AW  = MEM - 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_din;
  logic          done;
  logic          err;

  prog_loader #(.MEM(MEM)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_din  (prog_din),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
    int            due;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] bq[$];
  int         gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, on its due cycle.
  always @(negedge clk) begin
    if (rstn) begin
      chk("done_err_exclusive", 32'(done & err), 32'd0);
      if (prog_we) begin
        chk("write_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("write_addr", 32'(prog_addr), 32'(mon_e.addr));
          chk("write_data", prog_din, mon_e.data);
          chk("write_done", 32'(done), 32'(mon_e.last));
          chk("write_latency", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("write_missing", 32'(prog_we), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic push_w(input logic [31:0] w, input int gmax);
    for (int i = 3; i >= 0; i--) begin
      bq.push_back(w[8*i +: 8]);
      gq.push_back((gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
    end
  endtask

  task automatic push_b(input logic [7:0] b, input int gap);
    bq.push_back(b);
    gq.push_back(gap);
  endtask

  // Drive bq/gq into the DUT; the model derives expectations from the stream rules.
  task automatic load();
    logic [31:0] n;
    bit          exp_err;
    bit          exp_done;
    int          limit;
    int          nw;
    wr_t         pend[$];
    wr_t         w;
    logic        rdy;
    int          t;

    n        = {bq[0], bq[1], bq[2], bq[3]};
    exp_err  = (n > 32'(CAP));
    limit    = (n == 0 || exp_err) ? 4 : 4 + 4 * int'(n);
    nw       = (limit - 4) / 4;
    exp_done = !exp_err && (bq.size() >= limit);
    for (int i = 0; i < nw; i++) begin
      if (4 + 4*i + 3 < bq.size()) begin
        w.addr = AW'(i);
        w.data = {bq[4+4*i], bq[5+4*i], bq[6+4*i], bq[7+4*i]};
        w.last = (i == nw - 1);
        w.due  = 0;
        pend.push_back(w);
      end
    end

    for (int idx = 0; idx < bq.size(); idx++) begin
      if (gq[idx] > 0) begin
        rx_valid = 1'b0;
        repeat (gq[idx]) begin
          @(posedge clk);
          #1;
        end
      end
      rx_data  = bq[idx];
      rx_valid = 1'b1;
      if (idx < limit) begin
        t = 0;
        do begin
          rdy = rx_ready;
          @(posedge clk);
          #1;
          t++;
        end while (!rdy && t < 8);
        chk("byte_accepted", 32'(rdy), 32'd1);
        if (rdy && idx >= 4 && (idx % 4) == 3) begin
          w = pend[(idx - 4) / 4];
          w.due = cyc;
          sb.push_back(w);
        end
        if (idx == 3 && limit == 4) begin
          rx_valid = 1'b0;
          @(negedge clk);
          chk("hdr_done", 32'(done), 32'(n == 0));
          chk("hdr_err", 32'(err), 32'(exp_err));
        end
      end else begin
        repeat (2) begin
          chk("terminal_rx_ready", 32'(rx_ready), 32'd0);
          @(posedge clk);
          #1;
        end
      end
    end
    rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_done", 32'(done), 32'(exp_done));
    chk("final_err", 32'(err), 32'(exp_err));
    chk("final_rx_ready", 32'(rx_ready), 32'(!(exp_done || exp_err)));
    bq.delete();
    gq.delete();
  endtask

  // Asynchronous reset in mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    rx_valid = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_prog_din", prog_din, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rx_ready_before_edge", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rx_ready_after_edge", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    do_reset();

    // Two words back-to-back, then bytes that must be refused.
    push_w(32'h0000_0002, 0);
    push_w(32'h0102_0304, 0);
    push_w(32'hAABB_CCDD, 0);
    push_b(8'h55, 0);
    push_b(8'h66, 0);
    load();

    // Zero-length program.
    do_reset();
    push_w(32'h0000_0000, 0);
    push_b(8'h77, 0);
    load();

    // One word over capacity.
    do_reset();
    push_w(32'h0000_0101, 0);
    push_b(8'h12, 0);
    push_b(8'h34, 0);
    load();

    // Full capacity with random gaps.
    do_reset();
    push_w(32'(CAP), 1);
    for (int i = 0; i < CAP; i++) push_w($urandom, 2);
    load();

    // Reset mid-load after two of three words, then a fresh one-word load.
    do_reset();
    push_w(32'h0000_0003, 0);
    push_w($urandom, 1);
    push_w($urandom, 1);
    load();
    do_reset();
    push_w(32'h0000_0001, 0);
    push_w(32'hDEAD_BEEF, 0);
    load();

    // Five-cycle gap inside a data word.
    do_reset();
    push_w(32'h0000_0001, 0);
    push_b(8'h11, 0);
    push_b(8'h22, 5);
    push_b(8'h33, 0);
    push_b(8'h44, 0);
    load();

    // Short random loads.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      n = int'($urandom_range(1, 6));
      push_w(32'(n), 1);
      for (int i = 0; i < n; i++) push_w($urandom, 1);
      load();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
